// File: rtl/rf_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : rf_arb_pkg
// Brief  : Shared types and default widths for the register-file arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package rf_arb_pkg;

    localparam int c_DEF_ADDR_W  = 4;
    localparam int c_DEF_DATA_W  = 8;
    localparam int c_DEF_TIMEOUT = 15;
    localparam int c_CNT_W       = 8;

    typedef enum bit [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } rf_state_e;

    typedef bit req_id_t;

endpackage
`default_nettype wire

// File: rtl/rf_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin pick with a registered last-winner pointer.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arb2
    import rf_arb_pkg::*;
(
    input  logic    CLK,
    input  logic    RST,
    input  logic    i_req0,
    input  logic    i_req1,
    input  logic    i_grant,
    output logic    o_any,
    output req_id_t o_winner
);

    req_id_t r_ptr;
    req_id_t w_winner;

    // Under contention the side that did not win last time goes next.
    always_comb begin
        w_winner = req_id_t'(i_req1);
        if (i_req0 && i_req1) begin
            w_winner = ~r_ptr;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr <= 1'b0;
        end else if (i_grant && o_any) begin
            r_ptr <= w_winner;
        end
    end

    assign o_any    = i_req0 | i_req1;
    assign o_winner = w_winner;

endmodule
`default_nettype wire

// File: rtl/rf_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rf_arbiter
// Brief  : Round-robin arbiter sharing one register-file port between two
//          requesters, with read-data routing and a read timeout.
// Rev    : 1.0  initial release
// ============================================================================
module rf_arbiter
    import rf_arb_pkg::*;
#(
    parameter int ADDR_W  = c_DEF_ADDR_W,
    parameter int DATA_W  = c_DEF_DATA_W,
    parameter int TIMEOUT = c_DEF_TIMEOUT
)(
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic              rd0,
    input  logic              rd1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvld0,
    output logic              rvld1,
    output logic              rerr0,
    output logic              rerr1,
    output logic [ADDR_W-1:0] Address,
    output logic              WrEn,
    output logic              RdEn,
    output logic [DATA_W-1:0] WrData,
    input  logic [DATA_W-1:0] RdData,
    input  logic              RdData_Valid,
    output logic              busy
);

    localparam logic [1:0]         c_ST_IDLE    = 2'(IDLE);
    localparam logic [1:0]         c_ST_ISSUE   = 2'(ISSUE);
    localparam logic [1:0]         c_ST_WAIT_RD = 2'(WAIT_RD);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT    = c_CNT_W'(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    logic [1:0]         r_state;
    req_id_t            r_owner;
    logic               r_is_rd;
    logic [c_CNT_W-1:0] r_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_wren;
    logic               r_rden;
    logic               r_busy;
    logic [1:0]         r_ack;

    logic               w_idle;
    logic               w_any;
    req_id_t            w_winner;
    logic               w_sel_wr;
    logic               w_sel_rd;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic               w_timeout;
    logic               w_rd_done;

    assign w_idle = (r_state == c_ST_IDLE);

    rr_arb2 u_rr_arb2 (
        .CLK      (CLK),
        .RST      (RST),
        .i_req0   (req0),
        .i_req1   (req1),
        .i_grant  (w_idle),
        .o_any    (w_any),
        .o_winner (w_winner)
    );

    always_comb begin
        w_sel_wr    = wr0;
        w_sel_rd    = rd0;
        w_sel_addr  = addr0;
        w_sel_wdata = wdata0;
        if (w_winner) begin
            w_sel_wr    = wr1;
            w_sel_rd    = rd1;
            w_sel_addr  = addr1;
            w_sel_wdata = wdata1;
        end
    end

    // Valid on the timeout cycle still counts as data, so it is tested first downstream.
    assign w_timeout = (r_state == c_ST_WAIT_RD) && ((r_cnt + c_CNT_ONE) == c_TIMEOUT);
    assign w_rd_done = (r_state == c_ST_WAIT_RD) && (RdData_Valid || w_timeout);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_ST_IDLE;
            r_owner <= 1'b0;
            r_is_rd <= 1'b0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wren  <= 1'b0;
            r_rden  <= 1'b0;
            r_busy  <= 1'b0;
            r_ack   <= 2'b00;
        end else begin
            r_ack  <= 2'b00;
            r_wren <= 1'b0;
            r_rden <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any) begin
                        // Command is captured here; later field changes are ignored.
                        r_state         <= c_ST_ISSUE;
                        r_busy          <= 1'b1;
                        r_owner         <= w_winner;
                        r_addr          <= w_sel_addr;
                        r_wdata         <= w_sel_wdata;
                        r_wren          <= w_sel_wr;
                        r_rden          <= w_sel_rd & ~w_sel_wr;
                        r_is_rd         <= w_sel_rd & ~w_sel_wr;
                        r_ack[w_winner] <= 1'b1;
                    end
                end
                c_ST_ISSUE: begin
                    r_cnt <= '0;
                    if (r_is_rd) begin
                        r_state <= c_ST_WAIT_RD;
                    end else begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                c_ST_WAIT_RD: begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (w_rd_done) begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Per-requester return path; only the owner of the read sees a pulse.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
        localparam req_id_t c_ID = req_id_t'(gi);

        logic              r_rvld;
        logic              r_rerr;
        logic [DATA_W-1:0] r_rdata;

        always_ff @(posedge CLK) begin
            if (RST) begin
                r_rvld  <= 1'b0;
                r_rerr  <= 1'b0;
                r_rdata <= '0;
            end else begin
                r_rvld <= 1'b0;
                r_rerr <= 1'b0;
                if (w_rd_done && (r_owner == c_ID)) begin
                    r_rvld  <= 1'b1;
                    r_rerr  <= ~RdData_Valid;
                    r_rdata <= RdData_Valid ? RdData : '0;
                end
            end
        end
    end

    assign ack0    = r_ack[0];
    assign ack1    = r_ack[1];
    assign rvld0   = g_ret[0].r_rvld;
    assign rvld1   = g_ret[1].r_rvld;
    assign rerr0   = g_ret[0].r_rerr;
    assign rerr1   = g_ret[1].r_rerr;
    assign rdata0  = g_ret[0].r_rdata;
    assign rdata1  = g_ret[1].r_rdata;
    assign Address = r_addr;
    assign WrData  = r_wdata;
    assign WrEn    = r_wren;
    assign RdEn    = r_rden;
    assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rf_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_rf_arbiter
// Brief  : Self-checking bench for rf_arbiter with a small RF model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rf_arbiter;

    localparam int c_TO = 15;

    typedef struct packed {
        bit         id;
        bit         wren;
        bit         rden;
        logic [3:0] addr;
        logic [7:0] wdata;
    } gexp_t;

    typedef struct packed {
        bit         id;
        logic [7:0] data;
        bit         err;
    } rexp_t;

    typedef struct {
        bit         id;
        bit         wr;
        bit         rd;
        logic [3:0] addr;
        logic [7:0] wdata;
        int         lat;
        logic [7:0] rdata;
        bit         err;
        int         wcyc;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0, rd0 = 1'b0, rd1 = 1'b0;
    logic [3:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       ack0, ack1, rvld0, rvld1, rerr0, rerr1, WrEn, RdEn, busy;
    logic [7:0] rdata0, rdata1, WrData, RdData;
    logic [3:0] Address;
    logic       RdData_Valid;

    logic [7:0] mem [16];
    int         pend = 0;
    int         rf_lat = 0;
    logic [3:0] raddr = '0;
    logic       model_vld = 1'b0;
    logic       stray_vld = 1'b0;
    logic [7:0] model_data = '0;

    gexp_t      gq[$];
    rexp_t      rq[$];
    logic [7:0] hold0 = '0, hold1 = '0;
    bit         ack_seen, rvld_seen, ack_id;
    int         cyc = 0;
    int         n_chk = 0, n_pass = 0;
    vec_t       tbl [10];

    assign RdData_Valid = model_vld | stray_vld;
    assign RdData       = model_data;

    always #5 CLK = ~CLK;

    rf_arbiter #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(c_TO)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1), .rd0(rd0), .rd1(rd1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .rvld0(rvld0), .rvld1(rvld1), .rerr0(rerr0), .rerr1(rerr1),
        .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
        .RdData(RdData), .RdData_Valid(RdData_Valid), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic monitor();
        gexp_t g;
        rexp_t r;
        if (RST) begin
            gq.delete();
            rq.delete();
            hold0 = '0;
            hold1 = '0;
            return;
        end
        if (ack0 || ack1) begin
            ack_seen = 1'b1;
            ack_id   = ack1;
            if (gq.size() == 0) chk("ack_unexpected", {ack1, ack0}, 2'b00);
            else begin
                g = gq.pop_front();
                chk("ack_id", {ack1, ack0}, g.id ? 2'b10 : 2'b01);
                chk("wren", WrEn, g.wren);
                chk("rden", RdEn, g.rden);
                if (g.wren || g.rden) chk("address", Address, g.addr);
                if (g.wren) chk("wrdata", WrData, g.wdata);
            end
        end else begin
            chk("idle_en", {WrEn, RdEn}, 2'b00);
        end
        if (rvld0 || rvld1) begin
            rvld_seen = 1'b1;
            if (rq.size() == 0) chk("rvld_unexpected", {rvld1, rvld0}, 2'b00);
            else begin
                r = rq.pop_front();
                chk("rvld_id", {rvld1, rvld0}, r.id ? 2'b10 : 2'b01);
                chk("rerr", r.id ? rerr1 : rerr0, r.err);
                chk("rerr_other", r.id ? rerr0 : rerr1, 1'b0);
                if (r.id) hold1 = r.data;
                else      hold0 = r.data;
            end
        end else begin
            chk("rerr_idle", {rerr1, rerr0}, 2'b00);
        end
        chk("rdata0", rdata0, hold0);
        chk("rdata1", rdata1, hold1);
    endtask

    // RF model: responds rf_lat negedges after seeing RdEn; rf_lat==0 never responds.
    task automatic rf_model();
        model_vld = 1'b0;
        if (WrEn === 1'b1) mem[Address] = WrData;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                model_vld  = 1'b1;
                model_data = mem[raddr];
            end
        end
        if (RdEn === 1'b1) begin
            pend  = rf_lat;
            raddr = Address;
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        cyc++;
        monitor();
        rf_model();
    endtask

    task automatic drive(input bit id, input logic rq_, input logic w, input logic r,
                         input logic [3:0] a, input logic [7:0] d);
        if (id) begin req1 = rq_; wr1 = w; rd1 = r; addr1 = a; wdata1 = d; end
        else    begin req0 = rq_; wr0 = w; rd0 = r; addr0 = a; wdata0 = d; end
    endtask

    task automatic wait_ack();
        ack_seen = 1'b0;
        for (int i = 0; i < 4 && !ack_seen; i++) tick();
    endtask

    task automatic txn(input vec_t v);
        int    t0;
        gexp_t g;
        rexp_t r;
        bit    is_rd;
        is_rd  = v.rd && !v.wr;
        rf_lat = v.lat;
        g = '{id: v.id, wren: v.wr, rden: is_rd, addr: v.addr, wdata: v.wdata};
        gq.push_back(g);
        if (is_rd) begin
            r = '{id: v.id, data: v.rdata, err: v.err};
            rq.push_back(r);
        end
        drive(v.id, 1'b1, v.wr, v.rd, v.addr, v.wdata);
        t0 = cyc;
        wait_ack();
        chk("ack_latency", cyc - t0, 1);
        chk("busy_issue", busy, 1'b1);
        drive(v.id, 1'b0, 1'b0, 1'b0, ~v.addr, ~v.wdata);
        if (is_rd) begin
            t0 = cyc;
            rvld_seen = 1'b0;
            for (int i = 0; i < c_TO + 8 && !rvld_seen; i++) tick();
            chk("rd_latency", cyc - t0, v.wcyc);
        end else begin
            tick();
        end
        chk("busy_done", busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int    t0;
        int    n0, n1;
        gexp_t g;

        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[2]  = 8'hC3;
        mem[15] = 8'hE7;

        //         id    wr    rd    addr   wdata  lat      rdata  err   wait
        tbl[0] = '{1'b0, 1'b1, 1'b0, 4'h3, 8'h5A, 0,       8'h00, 1'b0, 0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 4'h2, 8'h00, 2,       8'hC3, 1'b0, 3};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 4'h3, 8'h00, 1,       8'h5A, 1'b0, 2};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 4'h3, 8'h00, 0,       8'h00, 1'b1, c_TO + 1};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 4'h7, 8'h81, 0,       8'h00, 1'b0, 0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 4'h7, 8'h00, c_TO,    8'h81, 1'b0, c_TO + 1};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 4'h4, 8'h3C, 3,       8'h00, 1'b0, 0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 4'h4, 8'h00, 3,       8'h3C, 1'b0, 4};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 4'h9, 8'h77, 0,       8'h00, 1'b0, 0};
        tbl[9] = '{1'b1, 1'b0, 1'b1, 4'hF, 8'h00, 1,       8'hE7, 1'b0, 2};

        RST = 1'b1;
        tick();
        tick();
        tick();
        chk("rst_ctrl", {ack0, ack1, rvld0, rvld1, rerr0, rerr1, WrEn, RdEn, busy}, 9'h0);
        chk("rst_data", {Address, WrData, rdata0, rdata1}, 28'h0);
        RST = 1'b0;
        tick();

        // Contention: two writes from each side, alternation starts with requester 1.
        g = '{id: 1'b1, wren: 1'b1, rden: 1'b0, addr: 4'h8, wdata: 8'h91}; gq.push_back(g);
        g = '{id: 1'b0, wren: 1'b1, rden: 1'b0, addr: 4'h0, wdata: 8'h01}; gq.push_back(g);
        g = '{id: 1'b1, wren: 1'b1, rden: 1'b0, addr: 4'h9, wdata: 8'h92}; gq.push_back(g);
        g = '{id: 1'b0, wren: 1'b1, rden: 1'b0, addr: 4'h1, wdata: 8'h02}; gq.push_back(g);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 8'h01);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h8, 8'h91);
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 4; k++) begin
            t0 = cyc;
            wait_ack();
            chk("cont_ack_gap", cyc - t0, (k == 0) ? 1 : 2);
            if (ack_id) begin
                n1++;
                if (n1 < 2) drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h9, 8'h92);
                else        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
            end else begin
                n0++;
                if (n0 < 2) drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h1, 8'h02);
                else        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
            end
        end
        tick();
        tick();
        chk("cont_grants_left", gq.size(), 0);
        chk("cont_busy", busy, 1'b0);

        for (int i = 0; i < 10; i++) txn(tbl[i]);

        // Stray valid while idle must not produce any return pulse.
        stray_vld = 1'b1;
        tick();
        stray_vld = 1'b0;
        tick();
        tick();
        chk("stray_busy", busy, 1'b0);

        // Reset in the middle of a read; the late RF response must be ignored.
        rf_lat = 6;
        g = '{id: 1'b0, wren: 1'b0, rden: 1'b1, addr: 4'h3, wdata: 8'hEE};
        gq.push_back(g);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 8'hEE);
        wait_ack();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        tick();
        tick();
        chk("midrd_busy", busy, 1'b1);
        RST = 1'b1;
        tick();
        chk("midrd_rst_ctrl", {ack0, ack1, rvld0, rvld1, rerr0, rerr1, WrEn, RdEn, busy}, 9'h0);
        chk("midrd_rst_data", {Address, WrData, rdata0, rdata1}, 28'h0);
        RST = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("midrd_late_busy", busy, 1'b0);

        txn(tbl[1]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
